// File: rtl/sum_acc_requant.sv
// sum_acc_requant: accumulates cfg_len signed sums per group, then
// round-shifts and saturates the total to WIDTH_OUT bits.
module sum_acc_requant #(
  parameter int WIDTH_SUM = 9,
  parameter int WIDTH_OUT = 8,
  parameter int MAX_LEN   = 64,
  parameter int WIDTH_LEN = 7,
  parameter int WIDTH_ACC = 16,
  parameter int WIDTH_SH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_LEN-1:0]        cfg_len,
  input  logic [WIDTH_SH-1:0]         cfg_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_SUM-1:0] in_sum,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_OUT-1:0] out_data,
  output logic                        out_sat
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  localparam logic signed [WIDTH_ACC:0] OMAX =
    (WIDTH_ACC+1)'((1 << (WIDTH_OUT-1)) - 1);
  localparam logic signed [WIDTH_ACC:0] OMIN = -OMAX - 1;

  state_t state, state_d;

  logic signed [WIDTH_ACC-1:0] acc, acc_d;
  logic [WIDTH_LEN-1:0] cnt, cnt_d;
  logic [WIDTH_LEN-1:0] len_q, len_d, len_c;
  logic [WIDTH_SH-1:0]  sh_q, sh_d, sh_use;
  logic                 beat, load;

  logic signed [WIDTH_ACC:0] ext, rnd, r;
  logic signed [WIDTH_OUT-1:0] data_d;
  logic                        sat_d;

  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);
  assign beat      = in_valid & in_ready;

  always_comb begin
    len_c = cfg_len;
    if (cfg_len == '0)
      len_c = WIDTH_LEN'(1);
    else if (cfg_len > WIDTH_LEN'(MAX_LEN))
      len_c = WIDTH_LEN'(MAX_LEN);
  end

  always_comb begin
    acc_d = acc;
    if (beat) begin
      if (state == IDLE)
        acc_d = WIDTH_ACC'(in_sum);
      else
        acc_d = acc + WIDTH_ACC'(in_sum);
    end
  end

  // Requantize the value the accumulator takes on this edge, so the
  // result lands in the output register together with the last sum.
  always_comb begin
    sh_use = (state == IDLE) ? cfg_shift : sh_q;
    ext    = {acc_d[WIDTH_ACC-1], acc_d};
    rnd    = '0;
    if (sh_use != '0)
      rnd[sh_use - 1'b1] = 1'b1;
    r      = (ext + rnd) >>> sh_use;
    data_d = r[WIDTH_OUT-1:0];
    sat_d  = 1'b0;
    if (r > OMAX) begin
      data_d = OMAX[WIDTH_OUT-1:0];
      sat_d  = 1'b1;
    end else if (r < OMIN) begin
      data_d = OMIN[WIDTH_OUT-1:0];
      sat_d  = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    len_d   = len_q;
    sh_d    = sh_q;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (beat) begin
          len_d = len_c;
          sh_d  = cfg_shift;
          cnt_d = WIDTH_LEN'(1);
          if (len_c == WIDTH_LEN'(1)) begin
            state_d = OUT;
            load    = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (beat) begin
          cnt_d = cnt + 1'b1;
          if (cnt == len_q - 1'b1) begin
            state_d = OUT;
            load    = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      len_q    <= WIDTH_LEN'(1);
      sh_q     <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      len_q <= len_d;
      sh_q  <= sh_d;
      if (load) begin
        out_data <= data_d;
        out_sat  <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_sum_acc_requant.sv
// tb_sum_acc_requant: directed table, hand sequences and random groups
// checked against an arithmetic model of the accumulate/requant rules.
module tb_sum_acc_requant;

  localparam int WIDTH_SUM = 9;
  localparam int WIDTH_OUT = 8;
  localparam int MAX_LEN   = 64;
  localparam int WIDTH_LEN = 7;
  localparam int WIDTH_ACC = 16;
  localparam int WIDTH_SH  = 4;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [WIDTH_LEN-1:0]        cfg_len;
  logic [WIDTH_SH-1:0]         cfg_shift;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH_SUM-1:0] in_sum;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [WIDTH_OUT-1:0] out_data;
  logic                        out_sat;

  int nvec = 0;
  int nerr = 0;

  sum_acc_requant #(
    .WIDTH_SUM(WIDTH_SUM),
    .WIDTH_OUT(WIDTH_OUT),
    .MAX_LEN  (MAX_LEN),
    .WIDTH_LEN(WIDTH_LEN),
    .WIDTH_ACC(WIDTH_ACC),
    .WIDTH_SH (WIDTH_SH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_len  (cfg_len),
    .cfg_shift(cfg_shift),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    len;
    int    sh;
    int    nsend;
    int    s[4];
    int    exp_d;
    int    exp_s;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input int sh, input int sums[$],
                                output int d, output int s);
    int tot;
    int r;
    tot = 0;
    foreach (sums[i]) tot += sums[i];
    if (sh == 0) r = tot;
    else r = (tot + (1 << (sh - 1))) >>> sh;
    s = 0;
    d = r;
    if (r > 127) begin d = 127; s = 1; end
    if (r < -128) begin d = -128; s = 1; end
  endfunction

  task automatic send_beat(input string nm, input int s, input int len,
                           input int sh, input bit first);
    int n;
    n = 0;
    @(negedge clk);
    chk({nm, "_busy_valid"}, int'(out_valid), 0);
    in_valid  = 1'b1;
    in_sum    = WIDTH_SUM'(s);
    cfg_len   = first ? WIDTH_LEN'(len) : WIDTH_LEN'($urandom);
    cfg_shift = first ? WIDTH_SH'(sh) : WIDTH_SH'($urandom);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({nm, "_ready_wait"}, int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_group(input string nm, input int len, input int sh,
                           input int sums[$], input int exp_d,
                           input int exp_s, input int hold,
                           input bit gaps);
    logic signed [WIDTH_OUT-1:0] d0;
    foreach (sums[i]) begin
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(nm, sums[i], len, sh, i == 0);
    end
    @(negedge clk);
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_data"}, int'(out_data), exp_d);
    chk({nm, "_sat"}, int'(out_sat), exp_s);
    d0 = out_data;
    repeat (hold) begin
      in_valid = 1'b1;
      in_sum   = WIDTH_SUM'($urandom);
      @(negedge clk);
      chk({nm, "_hold_valid"}, int'(out_valid), 1);
      chk({nm, "_hold_data"}, int'(out_data), int'(d0));
      chk({nm, "_hold_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_rel_ready"}, int'(in_ready), 1);
    chk({nm, "_rel_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    int q[$];
    int ed, es, len, n, sh;

    tbl[0] = '{"len4_basic", 4, 0, 4, '{10, 20, -5, 3}, 28, 0};
    tbl[1] = '{"len2_pos_rnd", 2, 2, 2, '{5, 1, 0, 0}, 2, 0};
    tbl[2] = '{"len2_neg_rnd", 2, 2, 2, '{-5, -1, 0, 0}, -1, 0};
    tbl[3] = '{"sat_pos", 4, 0, 4, '{255, 255, 255, 255}, 127, 1};
    tbl[4] = '{"sat_neg", 4, 0, 4, '{-256, -256, -256, -256}, -128, 1};
    tbl[5] = '{"len64_sh6", 64, 6, 64, '{-256, -256, -256, -256}, -128, 1};
    tbl[6] = '{"len0_as_1", 0, 0, 1, '{100, 0, 0, 0}, 100, 0};
    tbl[7] = '{"len100_as_64", 100, 0, 64, '{1, 1, 1, 1}, 64, 0};
    tbl[8] = '{"len1_sh1", 1, 1, 1, '{3, 0, 0, 0}, 2, 0};
    tbl[9] = '{"len3_neg_half", 3, 1, 3, '{-1, -1, -1, 0}, -1, 0};

    rst_n     = 1'b0;
    cfg_len   = '0;
    cfg_shift = '0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sat", int'(out_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    for (int v = 0; v < 10; v++) begin
      q = {};
      for (int i = 0; i < tbl[v].nsend; i++)
        q.push_back(tbl[v].s[i < 4 ? i : 3]);
      run_group(tbl[v].name, tbl[v].len, tbl[v].sh, q,
                tbl[v].exp_d, tbl[v].exp_s, 0, 1'b0);
    end

    q = {10, 20, -5, 3};
    run_group("out_hold", 4, 0, q, 28, 0, 5, 1'b0);

    // Reset after two beats of a four-beat group
    send_beat("rst_mid", 7, 4, 0, 1'b1);
    send_beat("rst_mid", 9, 4, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q = {1, 2, 3, 4};
    run_group("after_rst", 4, 0, q, 10, 0, 0, 1'b0);

    // Reset while a result is waiting
    send_beat("rst_out", 50, 1, 0, 1'b1);
    @(negedge clk);
    chk("rst_out_pre", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(0, 10);
      n   = (len == 0) ? 1 : len;
      sh  = $urandom_range(0, 15);
      q = {};
      for (int i = 0; i < n; i++)
        q.push_back(int'($urandom_range(0, 511)) - 256);
      model(sh, q, ed, es);
      run_group("rand", len, sh, q, ed, es,
                $urandom_range(0, 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
